// File: rtl/voice_event_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : voice_event_master_if
//  Description : Bundles two sets of signals for voice_event_master:
//                - the note-event valid/ready handshake
//                - the Avalon-MM write-master bus
//                master : the voice_event_master side
//                slave  : the event source plus the control register slave
//  Signals     : EV_VALID, EV_READY, EV_NOTE_ON, EV_NOTE[6:0]
//                AVM_ADDR[5:0], AVM_WRITE, AVM_CS, AVM_BYTE_EN[3:0]
//                AVM_WRITEDATA[31:0], AVM_WAITREQUEST
//  Revision    : 1.0  initial release
// ============================================================================
interface voice_event_master_if;
    logic        EV_VALID;
    logic        EV_READY;
    logic        EV_NOTE_ON;
    logic [6:0]  EV_NOTE;
    logic [5:0]  AVM_ADDR;
    logic        AVM_WRITE;
    logic        AVM_CS;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA;
    logic        AVM_WAITREQUEST;

    modport master (
        input  EV_VALID,
        input  EV_NOTE_ON,
        input  EV_NOTE,
        input  AVM_WAITREQUEST,
        output EV_READY,
        output AVM_ADDR,
        output AVM_WRITE,
        output AVM_CS,
        output AVM_BYTE_EN,
        output AVM_WRITEDATA
    );

    modport slave (
        output EV_VALID,
        output EV_NOTE_ON,
        output EV_NOTE,
        output AVM_WAITREQUEST,
        input  EV_READY,
        input  AVM_ADDR,
        input  AVM_WRITE,
        input  AVM_CS,
        input  AVM_BYTE_EN,
        input  AVM_WRITEDATA
    );
endinterface
`default_nettype wire

// File: rtl/voice_event_master.sv
`default_nettype none
// ============================================================================
//  Module      : voice_event_master
//  Description : Avalon-MM write master that turns note-on/note-off events
//                into writes to the synth control register file.
//                Each event is allocated one of NUM_VOICES voices.
//                Registers written per voice v:
//                  KEY  at KEY_BASE+v  : 1 = key down, 0 = key up
//                  FREQ at FREQ_BASE+v : note number
//  Ports       : CLK            system clock
//                RESET          synchronous active-high reset
//                bus (master)   event handshake and Avalon-MM write bus:
//                               EV_VALID/EV_READY/EV_NOTE_ON/EV_NOTE,
//                               AVM_ADDR/AVM_WRITE/AVM_CS/AVM_BYTE_EN,
//                               AVM_WRITEDATA/AVM_WAITREQUEST
//                VOICES_ACTIVE  per-voice key-held flags
//  Revision    : 1.0  initial release
// ============================================================================
module voice_event_master #(
    parameter int NUM_VOICES = 8,   // 1..8
    parameter int KEY_BASE   = 32,
    parameter int FREQ_BASE  = 40
) (
    input  wire logic                  CLK,
    input  wire logic                  RESET,
    voice_event_master_if.master       bus,
    output logic [NUM_VOICES-1:0]      VOICES_ACTIVE
);

    localparam int              c_VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [c_VW-1:0] c_LAST      = c_VW'(NUM_VOICES - 1);
    localparam logic [5:0]      c_KEY_ADDR  = 6'(KEY_BASE);
    localparam logic [5:0]      c_FREQ_ADDR = 6'(FREQ_BASE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WR_KOFF = 3'd2,
        S_WR_FREQ = 3'd3,
        S_WR_KON  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [6:0]        r_note;          // latched event note
    logic              r_note_on;       // latched event type
    logic [c_VW-1:0]   r_voice;         // voice chosen in LOOKUP
    logic [c_VW-1:0]   r_steal;         // round-robin steal pointer
    logic [NUM_VOICES-1:0] r_active;
    logic [6:0]        r_table [NUM_VOICES];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t            w_next;
    logic [c_VW-1:0]   w_sel_voice;
    logic              w_steal_adv;
    logic              w_wr_done;
    logic              w_ev_ready;
    logic              w_write;
    logic [5:0]        w_addr;
    logic [31:0]       w_wdata;
    logic              w_match_hit;
    logic [c_VW-1:0]   w_match_idx;
    logic              w_free_hit;
    logic [c_VW-1:0]   w_free_idx;
    logic [5:0]        w_voice_ext;

    assign w_voice_ext = {{(6 - c_VW){1'b0}}, r_voice};

    // Voice search over the table.
    // The loop runs high to low, so the last hit wins.
    // The result is therefore the lowest matching or free index.
    always_comb begin
        w_match_hit = 1'b0;
        w_match_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_active[i] && (r_table[i] == r_note)) begin
                w_match_hit = 1'b1;
                w_match_idx = c_VW'(i);
            end
            if (!r_active[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = c_VW'(i);
            end
        end
    end

    // Next state and bus outputs.
    // Bus outputs are decoded from the state register.
    // Consequences:
    //   - address, data and strobe hold while the slave stalls;
    //   - a reset edge drops the strobe on the following cycle.
    // Each write state advances on the first edge with AVM_WAITREQUEST low.
    // With a zero-wait slave this gives, counted in accept edges:
    //   - dropped note-off: next accept 2 edges later (LOOKUP only);
    //   - note-off: 3 edges (LOOKUP, KOFF);
    //   - new voice: 4 edges (LOOKUP, FREQ, KON);
    //   - steal or retrigger: 5 edges (LOOKUP, KOFF, FREQ, KON).
    always_comb begin
        w_next      = r_state;
        w_sel_voice = r_voice;
        w_steal_adv = 1'b0;
        w_wr_done   = 1'b0;
        w_ev_ready  = 1'b0;
        w_write     = 1'b0;
        w_addr      = 6'd0;
        w_wdata     = 32'd0;
        case (r_state)
            S_IDLE: begin
                w_ev_ready = ~RESET;
                if (bus.EV_VALID) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (r_note_on) begin
                    if (w_match_hit) begin
                        // Retrigger: release the key first so the envelope restarts.
                        w_sel_voice = w_match_idx;
                        w_next      = S_WR_KOFF;
                    end else if (w_free_hit) begin
                        w_sel_voice = w_free_idx;
                        w_next      = S_WR_FREQ;
                    end else begin
                        w_sel_voice = r_steal;
                        w_steal_adv = 1'b1;
                        w_next      = S_WR_KOFF;
                    end
                end else if (w_match_hit) begin
                    w_sel_voice = w_match_idx;
                    w_next      = S_WR_KOFF;
                end else begin
                    // Note-off for a note nobody holds: nothing to write.
                    w_next = S_IDLE;
                end
            end
            S_WR_KOFF: begin
                w_write   = 1'b1;
                w_addr    = c_KEY_ADDR + w_voice_ext;
                w_wdata   = 32'd0;
                w_wr_done = ~bus.AVM_WAITREQUEST;
                if (w_wr_done) begin
                    w_next = r_note_on ? S_WR_FREQ : S_IDLE;
                end
            end
            S_WR_FREQ: begin
                w_write   = 1'b1;
                w_addr    = c_FREQ_ADDR + w_voice_ext;
                w_wdata   = {25'd0, r_note};
                w_wr_done = ~bus.AVM_WAITREQUEST;
                if (w_wr_done) begin
                    w_next = S_WR_KON;
                end
            end
            S_WR_KON: begin
                w_write   = 1'b1;
                w_addr    = c_KEY_ADDR + w_voice_ext;
                w_wdata   = 32'd1;
                w_wr_done = ~bus.AVM_WAITREQUEST;
                if (w_wr_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_note    <= 7'd0;
            r_note_on <= 1'b0;
            r_voice   <= '0;
            r_steal   <= '0;
            r_active  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_table[i] <= 7'd0;
            end
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && bus.EV_VALID) begin
                r_note    <= bus.EV_NOTE;
                r_note_on <= bus.EV_NOTE_ON;
            end

            if (r_state == S_LOOKUP) begin
                r_voice <= w_sel_voice;
            end

            if (w_steal_adv) begin
                r_steal <= (r_steal == c_LAST) ? '0 : r_steal + 1'b1;
            end

            // The table follows the slave.
            // It changes only when a KEY write actually completes.
            if (w_wr_done) begin
                if (r_state == S_WR_KOFF) begin
                    r_active[r_voice] <= 1'b0;
                end else if (r_state == S_WR_KON) begin
                    r_active[r_voice] <= 1'b1;
                    r_table[r_voice]  <= r_note;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.EV_READY      = w_ev_ready;
    assign bus.AVM_WRITE     = w_write;
    assign bus.AVM_CS        = w_write;
    assign bus.AVM_BYTE_EN   = w_write ? 4'hF : 4'h0;
    assign bus.AVM_ADDR      = w_addr;
    assign bus.AVM_WRITEDATA = w_wdata;
    assign VOICES_ACTIVE     = r_active;

endmodule
`default_nettype wire

// File: tb/tb_voice_event_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_event_master
//  Description : Directed self-checking bench for voice_event_master.
//                A negedge slave model logs every completed write.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_voice_event_master;

    logic       CLK;
    logic       RESET;
    logic [7:0] va;

    voice_event_master_if bus ();

    voice_event_master #(
        .NUM_VOICES (8),
        .KEY_BASE   (32),
        .FREQ_BASE  (40)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .bus           (bus),
        .VOICES_ACTIVE (va)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Slave model: a write completes at the coming edge if the strobe is up and no stall.
    logic [5:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic        q_cs   [$];
    logic [3:0]  q_be   [$];
    int          q_cyc  [$];

    always @(negedge CLK) begin
        if (!RESET && bus.AVM_WRITE && !bus.AVM_WAITREQUEST) begin
            q_addr.push_back(bus.AVM_ADDR);
            q_data.push_back(bus.AVM_WRITEDATA);
            q_cs.push_back(bus.AVM_CS);
            q_be.push_back(bus.AVM_BYTE_EN);
            q_cyc.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare logged write idx against (addr, data); CS=1 and BYTE_EN=F are expected too.
    task automatic chk_wr(input string tag, input int idx, input logic [5:0] addr, input logic [31:0] data);
        if (idx >= q_addr.size()) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: write %0d missing, only %0d logged", tag, idx, q_addr.size());
        end else begin
            chk(tag, {q_addr[idx], q_data[idx], q_cs[idx], q_be[idx]}, {addr, data, 1'b1, 4'hF});
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        bus.EV_VALID = 1'b0;
        bus.AVM_WAITREQUEST = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    // Present an event and hold it until the acceptance edge.
    task automatic send(input logic on, input logic [6:0] note);
        int k;
        k = 0;
        @(posedge CLK);
        #1;
        bus.EV_VALID   = 1'b1;
        bus.EV_NOTE_ON = on;
        bus.EV_NOTE    = note;
        forever begin
            @(negedge CLK);
            if (bus.EV_READY) break;
            k++;
            if (k > 50) begin
                n_chk++;
                n_fail++;
                $error("FAIL accept_timeout: EV_READY observed 0 expected 1");
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus.EV_VALID = 1'b0;
    endtask

    // Count edges from acceptance to the next edge able to accept.
    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!bus.EV_READY && lat < 30);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int base;

        RESET = 1'b1;
        bus.EV_VALID = 1'b0;
        bus.EV_NOTE_ON = 1'b0;
        bus.EV_NOTE = 7'd0;
        bus.AVM_WAITREQUEST = 1'b0;
        repeat (3) @(posedge CLK);

        // ---- Reset state ----
        @(negedge CLK);
        chk("rst_ready", bus.EV_READY, 1'b0);
        chk("rst_bus", {bus.AVM_WRITE, bus.AVM_CS, bus.AVM_ADDR, bus.AVM_WRITEDATA, bus.AVM_BYTE_EN}, 44'd0);
        chk("rst_active", va, 8'h00);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", bus.EV_READY, 1'b1);

        // ---- 1: single note-on ----
        base = q_addr.size();
        send(1'b1, 7'd60);
        wait_ready(lat);
        chk("t1_latency", lat, 4);
        chk_wr("t1_freq", base, 6'd40, 32'd60);
        chk_wr("t1_kon", base + 1, 6'd32, 32'd1);
        if (q_cyc.size() >= base + 2) chk("t1_back2back", q_cyc[base + 1] - q_cyc[base], 1);
        chk("t1_active", va, 8'h01);

        // ---- 2: three note-ons, note-off 62 ----
        do_reset();
        base = q_addr.size();
        send(1'b1, 7'd60); wait_ready(lat);
        send(1'b1, 7'd62); wait_ready(lat);
        send(1'b1, 7'd64); wait_ready(lat);
        chk_wr("t2_freq_v1", base + 2, 6'd41, 32'd62);
        chk_wr("t2_freq_v2", base + 4, 6'd42, 32'd64);
        chk("t2_active_3", va, 8'h07);
        send(1'b0, 7'd62);
        wait_ready(lat);
        chk("t2_off_latency", lat, 3);
        chk_wr("t2_koff", base + 6, 6'd33, 32'd0);
        chk("t2_count", q_addr.size(), base + 7);
        chk("t2_active", va, 8'h05);

        // ---- 5: note-off with no holder ----
        base = q_addr.size();
        send(1'b0, 7'd70);
        wait_ready(lat);
        chk("t5_latency", lat, 2);
        chk("t5_no_write", q_addr.size(), base);
        chk("t5_active", va, 8'h05);

        // ---- 3: nine note-ons, steal, retrigger ----
        do_reset();
        base = q_addr.size();
        for (int n = 60; n <= 68; n++) begin
            send(1'b1, 7'(n));
            wait_ready(lat);
        end
        chk("t3_steal_latency", lat, 5);
        chk_wr("t3_steal_koff", base + 16, 6'd32, 32'd0);
        chk_wr("t3_steal_freq", base + 17, 6'd40, 32'd68);
        chk_wr("t3_steal_kon", base + 18, 6'd32, 32'd1);
        chk("t3_active_full", va, 8'hFF);
        send(1'b1, 7'd69);
        wait_ready(lat);
        chk_wr("t3_steal2_koff", base + 19, 6'd33, 32'd0);
        chk_wr("t3_steal2_freq", base + 20, 6'd41, 32'd69);
        chk_wr("t3_steal2_kon", base + 21, 6'd33, 32'd1);
        send(1'b1, 7'd65);
        wait_ready(lat);
        chk("t3_retrig_latency", lat, 5);
        chk_wr("t3_retrig_koff", base + 22, 6'd37, 32'd0);
        chk_wr("t3_retrig_freq", base + 23, 6'd45, 32'd65);
        chk_wr("t3_retrig_kon", base + 24, 6'd37, 32'd1);
        send(1'b1, 7'd71);
        wait_ready(lat);
        chk_wr("t3_steal3_koff", base + 25, 6'd34, 32'd0);
        chk_wr("t3_steal3_freq", base + 26, 6'd42, 32'd71);

        // ---- 4: stalled FREQ write ----
        do_reset();
        @(posedge CLK);
        #1;
        bus.AVM_WAITREQUEST = 1'b1;
        base = q_addr.size();
        send(1'b1, 7'd60);
        @(negedge CLK);
        chk("t4_lookup_idle", bus.AVM_WRITE, 1'b0);
        for (int s = 0; s < 3; s++) begin
            @(negedge CLK);
            chk("t4_hold", {bus.AVM_WRITE, bus.AVM_CS, bus.AVM_BYTE_EN, bus.AVM_ADDR, bus.AVM_WRITEDATA},
                {1'b1, 1'b1, 4'hF, 6'd40, 32'd60});
        end
        @(posedge CLK);
        #1;
        bus.AVM_WAITREQUEST = 1'b0;
        wait_ready(lat);
        chk("t4_ready", bus.EV_READY, 1'b1);
        chk("t4_count", q_addr.size(), base + 2);
        chk_wr("t4_freq", base, 6'd40, 32'd60);
        chk_wr("t4_kon", base + 1, 6'd32, 32'd1);
        chk("t4_active", va, 8'h01);

        // ---- 6: reset during a stalled write ----
        @(posedge CLK);
        #1;
        bus.AVM_WAITREQUEST = 1'b1;
        base = q_addr.size();
        send(1'b1, 7'd72);
        @(negedge CLK);
        @(negedge CLK);
        chk("t6_stalled", {bus.AVM_WRITE, bus.AVM_ADDR, bus.AVM_WRITEDATA}, {1'b1, 6'd41, 32'd72});
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        bus.AVM_WAITREQUEST = 1'b0;
        @(negedge CLK);
        chk("t6_write_dropped", bus.AVM_WRITE, 1'b0);
        chk("t6_active_cleared", va, 8'h00);
        chk("t6_no_write", q_addr.size(), base);
        send(1'b1, 7'd50);
        wait_ready(lat);
        chk_wr("t6_freq_v0", base, 6'd40, 32'd50);
        chk_wr("t6_kon_v0", base + 1, 6'd32, 32'd1);
        chk("t6_active", va, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
